// File: rtl/axis_width_downsizer_if.sv
// Stream bundle for axis_width_downsizer: the wide s_axis side and the narrow m_axis side.
// The slave modport is the downsizer's view; the master modport is the upstream/downstream view.
interface axis_width_downsizer_if #(
    parameter int S_DATA_WIDTH = 64,
    parameter int M_DATA_WIDTH = 8
);
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic [S_DATA_WIDTH-1:0] s_axis_tdata;
    logic                    s_axis_tlast;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic [M_DATA_WIDTH-1:0] m_axis_tdata;
    logic                    m_axis_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/axis_width_downsizer.sv
// Splits each S_DATA_WIDTH word into RATIO M_DATA_WIDTH beats, one beat per cycle, tlast on the final lane.
// Define AXIS_DOWNSIZER_MSB_FIRST_EN to emit the most significant lane first (default: least significant first).
module axis_width_downsizer #(
    parameter int S_DATA_WIDTH = 64,
    parameter int M_DATA_WIDTH = 8
) (
    input logic                 aclk,
    input logic                 areset,
    axis_width_downsizer_if.slave bus
);
    localparam int RATIO  = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

    if (((S_DATA_WIDTH % M_DATA_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_ratio
        $error("axis_width_downsizer: S_DATA_WIDTH (%0d) must be an integer multiple >= 2 of M_DATA_WIDTH (%0d)",
               S_DATA_WIDTH, M_DATA_WIDTH);
    end

    typedef enum logic {
        ST_EMPTY,
        ST_DRAIN
    } state_t;

    state_t                  r_state;
    logic [S_DATA_WIDTH-1:0] r_hold_data;
    logic                    r_hold_last;
    logic [LANE_W-1:0]       r_lane_cnt;

    logic                    w_hold_valid;
    logic                    w_lane_is_last;
    logic                    w_s_ready;
    logic                    w_s_hs;
    logic                    w_m_hs;
    logic [M_DATA_WIDTH-1:0] w_lane_data;

    assign w_hold_valid   = (r_state == ST_DRAIN);
    assign w_lane_is_last = (r_lane_cnt == LANE_LAST);
    // Refill is allowed in the very cycle the last lane leaves, which keeps the output bubble-free.
    assign w_s_ready      = ~areset & (~w_hold_valid | (bus.m_axis_tready & w_lane_is_last));
    assign w_s_hs         = bus.s_axis_tvalid & w_s_ready;
    assign w_m_hs         = w_hold_valid & bus.m_axis_tready;

    always_comb begin
        w_lane_data = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (r_lane_cnt == LANE_W'(k)) begin
`ifdef AXIS_DOWNSIZER_MSB_FIRST_EN
                w_lane_data = r_hold_data[S_DATA_WIDTH-1-k*M_DATA_WIDTH -: M_DATA_WIDTH];
`else
                w_lane_data = r_hold_data[k*M_DATA_WIDTH +: M_DATA_WIDTH];
`endif
            end
        end
    end

    assign bus.s_axis_tready = w_s_ready;
    assign bus.m_axis_tvalid = w_hold_valid;
    assign bus.m_axis_tdata  = w_lane_data;
    assign bus.m_axis_tlast  = r_hold_last & w_lane_is_last;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_EMPTY;
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
            r_lane_cnt  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_s_hs) begin
                        r_hold_data <= bus.s_axis_tdata;
                        r_hold_last <= bus.s_axis_tlast;
                        r_lane_cnt  <= '0;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_m_hs) begin
                        if (w_lane_is_last) begin
                            r_lane_cnt <= '0;
                            if (w_s_hs) begin
                                r_hold_data <= bus.s_axis_tdata;
                                r_hold_last <= bus.s_axis_tlast;
                            end else begin
                                r_state <= ST_EMPTY;
                            end
                        end else begin
                            r_lane_cnt <= r_lane_cnt + LANE_W'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_width_downsizer.sv
// Directed bench for axis_width_downsizer: 64->8 main instance plus a 32->8 instance for the short lane counter.
module tb_axis_width_downsizer;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 aclk = ~aclk;

    axis_width_downsizer_if #(.S_DATA_WIDTH(64), .M_DATA_WIDTH(8)) if64 ();
    axis_width_downsizer_if #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8)) if32 ();

    axis_width_downsizer #(.S_DATA_WIDTH(64), .M_DATA_WIDTH(8)) u_dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (if64)
    );

    axis_width_downsizer #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8)) u_dut32 (
        .aclk   (aclk),
        .areset (areset),
        .bus    (if32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte k of a word of nl bytes in wire order.
    function automatic logic [7:0] exp_lane(input logic [63:0] w, input int nl, input int k);
        int idx;
`ifdef AXIS_DOWNSIZER_MSB_FIRST_EN
        idx = nl - 1 - k;
`else
        idx = k;
`endif
        return w[idx*8 +: 8];
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    logic [63:0] w1, w3, w4, w32a, w32b;
    logic [8:0]  q[$];
    logic [8:0]  ev;
    logic        s_hs, m_hs, lst;
    int          sent, in_lasts, out_lasts, cyc;

    initial begin
        w1   = 64'h0807_0605_0403_0201;
        w3   = 64'h1F1E_1D1C_1B1A_1918;
        w4   = 64'hDEAD_BEEF_CAFE_F00D;
        w32a = 64'h0000_0000_A1B2_C3D4;
        w32b = 64'h0000_0000_5566_7788;
        if64.s_axis_tvalid = 1'b0;
        if64.s_axis_tdata  = '0;
        if64.s_axis_tlast  = 1'b0;
        if64.m_axis_tready = 1'b0;
        if32.s_axis_tvalid = 1'b0;
        if32.s_axis_tdata  = '0;
        if32.s_axis_tlast  = 1'b0;
        if32.m_axis_tready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_m_tvalid", if64.m_axis_tvalid, 1'b0);
        check("rst_m_tlast",  if64.m_axis_tlast,  1'b0);
        check("rst_m_tdata",  if64.m_axis_tdata,  8'h00);
        check("rst_s_tready", if64.s_axis_tready, 1'b0);
        areset = 1'b0;
        step();
        check("rel_s_tready", if64.s_axis_tready, 1'b1);
        check("rel_m_tvalid", if64.m_axis_tvalid, 1'b0);

        // Single word with tlast
        if64.s_axis_tvalid = 1'b1;
        if64.s_axis_tdata  = w1;
        if64.s_axis_tlast  = 1'b1;
        if64.m_axis_tready = 1'b1;
        step();
        if64.s_axis_tvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("w1_tvalid", if64.m_axis_tvalid, 1'b1);
            check("w1_tdata",  if64.m_axis_tdata,  exp_lane(w1, 8, k));
            check("w1_tlast",  if64.m_axis_tlast,  (k == 7));
            check("w1_s_tready", if64.s_axis_tready, (k == 7));
            step();
        end
        check("w1_done_tvalid", if64.m_axis_tvalid, 1'b0);

        // Two back-to-back words
        if64.s_axis_tvalid = 1'b1;
        if64.s_axis_tdata  = 64'h1111_1111_1111_1111;
        if64.s_axis_tlast  = 1'b0;
        step();
        if64.s_axis_tdata  = 64'h2222_2222_2222_2222;
        if64.s_axis_tlast  = 1'b1;
        for (int b = 0; b < 16; b++) begin
            if (b == 8) if64.s_axis_tvalid = 1'b0;
            #1;
            check("b2b_tvalid", if64.m_axis_tvalid, 1'b1);
            check("b2b_tdata",  if64.m_axis_tdata,  (b < 8) ? 8'h11 : 8'h22);
            check("b2b_tlast",  if64.m_axis_tlast,  (b == 15));
            check("b2b_s_tready", if64.s_axis_tready, (b == 7 || b == 15));
            step();
        end
        check("b2b_done_tvalid", if64.m_axis_tvalid, 1'b0);

        // Stalls on lanes 3 and 7
        if64.s_axis_tvalid = 1'b1;
        if64.s_axis_tdata  = w3;
        if64.s_axis_tlast  = 1'b1;
        step();
        if64.s_axis_tvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3 || k == 7) begin
                if64.m_axis_tready = 1'b0;
                repeat (5) begin
                    #1;
                    check("stall_tvalid", if64.m_axis_tvalid, 1'b1);
                    check("stall_tdata",  if64.m_axis_tdata,  exp_lane(w3, 8, k));
                    check("stall_tlast",  if64.m_axis_tlast,  (k == 7));
                    check("stall_s_tready", if64.s_axis_tready, 1'b0);
                    step();
                end
                if64.m_axis_tready = 1'b1;
            end
            #1;
            check("stall_go_tdata", if64.m_axis_tdata, exp_lane(w3, 8, k));
            check("stall_go_tlast", if64.m_axis_tlast, (k == 7));
            step();
        end
        check("stall_done_tvalid", if64.m_axis_tvalid, 1'b0);

        // Reset mid-word
        if64.s_axis_tvalid = 1'b1;
        if64.s_axis_tdata  = w4;
        if64.s_axis_tlast  = 1'b1;
        step();
        if64.s_axis_tvalid = 1'b0;
        step();
        step();
        step();
        check("mid_lane3", if64.m_axis_tdata, exp_lane(w4, 8, 3));
        areset = 1'b1;
        step();
        check("mid_rst_tvalid", if64.m_axis_tvalid, 1'b0);
        check("mid_rst_s_tready", if64.s_axis_tready, 1'b0);
        areset = 1'b0;
        #1;
        check("mid_rel_s_tready", if64.s_axis_tready, 1'b1);
        if64.s_axis_tvalid = 1'b1;
        if64.s_axis_tdata  = 64'h0;
        if64.s_axis_tlast  = 1'b0;
        step();
        if64.s_axis_tvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("zero_tvalid", if64.m_axis_tvalid, 1'b1);
            check("zero_tdata",  if64.m_axis_tdata,  8'h00);
            step();
        end
        check("zero_done_tvalid", if64.m_axis_tvalid, 1'b0);

        // Random valid/ready over 1000 words against a byte queue
        sent = 0;
        in_lasts = 0;
        out_lasts = 0;
        cyc = 0;
        while ((sent < 1000 || q.size() != 0) && cyc < 60000) begin
            if (!if64.s_axis_tvalid && sent < 1000 && $urandom_range(1, 0) == 1) begin
                if64.s_axis_tvalid = 1'b1;
                if64.s_axis_tdata  = {$urandom(), $urandom()};
                if64.s_axis_tlast  = ($urandom_range(3, 0) == 0);
            end
            if64.m_axis_tready = ($urandom_range(1, 0) == 1);
            #1;
            s_hs = if64.s_axis_tvalid && if64.s_axis_tready;
            m_hs = if64.m_axis_tvalid && if64.m_axis_tready;
            if (m_hs) begin
                if (if64.m_axis_tlast) out_lasts++;
                check("rnd_beat_expected", (q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    ev = q.pop_front();
                    check("rnd_tdata", if64.m_axis_tdata, ev[7:0]);
                    check("rnd_tlast", if64.m_axis_tlast, ev[8]);
                end
            end
            if (s_hs) begin
                for (int k = 0; k < 8; k++) begin
                    lst = if64.s_axis_tlast && (k == 7);
                    q.push_back({lst, exp_lane(if64.s_axis_tdata, 8, k)});
                end
                sent++;
                if (if64.s_axis_tlast) in_lasts++;
            end
            @(posedge aclk);
            #1;
            cyc++;
            if (s_hs) if64.s_axis_tvalid = 1'b0;
        end
        check("rnd_in_time", (cyc < 60000), 1'b1);
        check("rnd_words", sent, 1000);
        check("rnd_tlast_count", out_lasts, in_lasts);
        if64.m_axis_tready = 1'b0;

        // 32->8 instance: two words back-to-back, 2-bit lane counter wraps between them
        if32.s_axis_tvalid = 1'b1;
        if32.s_axis_tdata  = w32a[31:0];
        if32.s_axis_tlast  = 1'b0;
        if32.m_axis_tready = 1'b1;
        step();
        if32.s_axis_tdata  = w32b[31:0];
        if32.s_axis_tlast  = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (b == 4) if32.s_axis_tvalid = 1'b0;
            #1;
            check("w32_tvalid", if32.m_axis_tvalid, 1'b1);
            check("w32_tdata", if32.m_axis_tdata,
                  (b < 4) ? exp_lane(w32a, 4, b) : exp_lane(w32b, 4, b - 4));
            check("w32_tlast", if32.m_axis_tlast, (b == 7));
            check("w32_s_tready", if32.s_axis_tready, (b == 3 || b == 7));
            step();
        end
        check("w32_done_tvalid", if32.m_axis_tvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
